// File: rtl/act_skew_feeder.sv
// Skewed activation feeder for a systolic array: lane j of each accepted vector reaches its column top j+1 cycles later.
// Optional build macro ACT_SKEW_PERF_EN adds the STALL_CNT performance counter.
module act_skew_feeder #(
  parameter int unsigned COLS = 4,
  parameter int unsigned ROWS = 4,
  parameter int unsigned DW   = 8
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [15:0]          TILE_LEN,
  input  logic                 S_VALID,
  output logic                 S_READY,
  input  logic [COLS*DW-1:0]   S_DATA,
  output logic [COLS*DW-1:0]   A_TOP,
  output logic [COLS-1:0]      EN_TOP,
  output logic                 ARRAY_EN,
  output logic                 BUSY,
  output logic                 DONE
`ifdef ACT_SKEW_PERF_EN
  ,
  output logic [15:0]          STALL_CNT
`endif
);

  localparam int unsigned LW        = 16;
  localparam int unsigned DRAIN_LEN = COLS + ROWS;
  localparam int unsigned CW        = $clog2(DRAIN_LEN + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t          state_q, state_n;
  logic [LW-1:0]   len_q, len_n;
  logic [LW-1:0]   beat_q, beat_n;
  logic [CW-1:0]   drain_q, drain_n;
  logic            accept_c;

  // A beat only enters the skew line if the cycle is not being aborted.
  assign accept_c = S_VALID && S_READY && !ABORT;

  // Next-state and counter logic.
  always_comb begin
    state_n = state_q;
    len_n   = len_q;
    beat_n  = beat_q;
    drain_n = drain_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          len_n   = TILE_LEN;
          beat_n  = '0;
          drain_n = '0;
          state_n = (TILE_LEN == '0) ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        if (accept_c) begin
          beat_n = beat_q + LW'(1);
        end
        // Leave one cycle after the final beat was counted.
        if (beat_q == len_q) begin
          state_n = DRAIN;
          drain_n = '0;
        end
      end
      DRAIN: begin
        if (drain_q == CW'(DRAIN_LEN - 1)) begin
          state_n = FINISH;
        end else begin
          drain_n = drain_q + CW'(1);
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (ABORT) begin
      state_n = IDLE;
      beat_n  = '0;
      drain_n = '0;
    end
  end

  // State, counters and registered status outputs derived from the next state.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      len_q    <= '0;
      beat_q   <= '0;
      drain_q  <= '0;
      S_READY  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ARRAY_EN <= 1'b0;
    end else begin
      state_q  <= state_n;
      len_q    <= len_n;
      beat_q   <= beat_n;
      drain_q  <= drain_n;
      S_READY  <= (state_n == STREAM) && (beat_n != len_n);
      BUSY     <= (state_n != IDLE);
      DONE     <= (state_n == FINISH);
      ARRAY_EN <= BUSY;
    end
  end

  // Per-lane delay lines; lane j is j+1 registers deep, bubbles carry zero data.
  for (genvar j = 0; j < COLS; j++) begin : g_lane
    logic [DW-1:0] d_q [0:j];
    logic          v_q [0:j];

    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        for (int k = 0; k <= j; k++) begin
          d_q[k] <= '0;
          v_q[k] <= 1'b0;
        end
      end else if (ABORT) begin
        for (int k = 0; k <= j; k++) begin
          d_q[k] <= '0;
          v_q[k] <= 1'b0;
        end
      end else begin
        d_q[0] <= accept_c ? S_DATA[j*DW +: DW] : '0;
        v_q[0] <= accept_c;
        for (int k = 1; k <= j; k++) begin
          d_q[k] <= d_q[k-1];
          v_q[k] <= v_q[k-1];
        end
      end
    end

    assign A_TOP[j*DW +: DW] = d_q[j];
    assign EN_TOP[j]         = v_q[j];
  end

`ifdef ACT_SKEW_PERF_EN
  // Counts STREAM cycles with no upstream data, saturating.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      STALL_CNT <= '0;
    end else if ((state_q == IDLE) && START && !ABORT) begin
      STALL_CNT <= '0;
    end else if ((state_q == STREAM) && !S_VALID && (STALL_CNT != 16'hFFFF)) begin
      STALL_CNT <= STALL_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_act_skew_feeder.sv
// Self-checking bench for act_skew_feeder: tile table plus abort/reset sequences, lane scoreboard.
module tb_act_skew_feeder;

  localparam int COLS = 4;
  localparam int DW   = 8;

  logic              CLK;
  logic              RSTN;
  logic              START;
  logic              ABORT;
  logic [15:0]       TILE_LEN;
  logic              S_VALID;
  logic              S_READY;
  logic [COLS*DW-1:0] S_DATA;
  logic [COLS*DW-1:0] A_TOP;
  logic [COLS-1:0]   EN_TOP;
  logic              ARRAY_EN;
  logic              BUSY;
  logic              DONE;
`ifdef ACT_SKEW_PERF_EN
  logic [15:0]       STALL_CNT;
`endif

  act_skew_feeder #(.COLS(4), .ROWS(4), .DW(8)) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .START    (START),
    .ABORT    (ABORT),
    .TILE_LEN (TILE_LEN),
    .S_VALID  (S_VALID),
    .S_READY  (S_READY),
    .S_DATA   (S_DATA),
    .A_TOP    (A_TOP),
    .EN_TOP   (EN_TOP),
    .ARRAY_EN (ARRAY_EN),
    .BUSY     (BUSY),
    .DONE     (DONE)
`ifdef ACT_SKEW_PERF_EN
    ,
    .STALL_CNT(STALL_CNT)
`endif
  );

  typedef struct {
    int         due;
    int         lane;
    logic [7:0] data;
  } exp_t;

  // len, beats before the gap, gap length, START->DONE latency, offset of a stray START (0 = none), fixed data
  typedef struct {
    int len;
    int gap_after;
    int gap_cycles;
    int done_lat;
    int drain_start;
    bit fixed;
  } tcase_t;

  exp_t       exp_q[$];
  tcase_t     tbl[6];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic       ee [COLS];
  logic [7:0] ed [COLS];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Scoreboard: every lane is compared every cycle; absent entries mean a bubble.
  always @(negedge CLK) begin
    for (int j = 0; j < COLS; j++) begin
      ee[j] = 1'b0;
      ed[j] = 8'd0;
    end
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due <= cyc) begin
        if (exp_q[i].due == cyc) begin
          ee[exp_q[i].lane] = 1'b1;
          ed[exp_q[i].lane] = exp_q[i].data;
        end
        exp_q.delete(i);
      end
    end
    for (int j = 0; j < COLS; j++) begin
      chk($sformatf("en_top[%0d]", j), int'(EN_TOP[j]), int'(ee[j]));
      chk($sformatf("a_top[%0d]", j), int'(A_TOP[j*DW +: DW]), int'(ed[j]));
    end
  end

  task automatic push_beat(input int n, input logic [31:0] d);
    exp_t e;
    for (int j = 0; j < COLS; j++) begin
      e.due  = n + j + 1;
      e.lane = j;
      e.data = d[j*8 +: 8];
      exp_q.push_back(e);
    end
  endtask

  task automatic run_tile(input tcase_t tc);
    int          sent;
    int          gap_left;
    logic [31:0] d;
    sent     = 0;
    gap_left = tc.gap_cycles;
    @(negedge CLK);
    START    = 1'b1;
    TILE_LEN = 16'(tc.len);
    S_VALID  = 1'b0;
    ABORT    = 1'b0;
    chk("busy_at_start", int'(BUSY), 0);
    chk("ready_at_start", int'(S_READY), 0);
    for (int k = 1; k <= tc.done_lat + 3; k++) begin
      @(negedge CLK);
      START    = (tc.drain_start != 0) && (k == tc.drain_start);
      TILE_LEN = 16'd3;
      chk("s_ready", int'(S_READY), int'(sent < tc.len));
      chk("busy", int'(BUSY), int'(k <= tc.done_lat));
      chk("array_en", int'(ARRAY_EN), int'(k >= 2 && k <= tc.done_lat + 1));
      chk("done", int'(DONE), int'(k == tc.done_lat));
`ifdef ACT_SKEW_PERF_EN
      if (k == 1) chk("stall_cnt_after_start", int'(STALL_CNT), 0);
      if (k == tc.done_lat) chk("stall_cnt_at_done", int'(STALL_CNT), tc.gap_cycles);
`endif
      if (sent == tc.gap_after && gap_left > 0 && sent < tc.len) begin
        S_VALID  = 1'b0;
        gap_left = gap_left - 1;
      end else begin
        S_VALID = 1'b1;
        d       = tc.fixed ? 32'h04030201 : $urandom;
        S_DATA  = d;
        if (sent < tc.len) begin
          push_beat(cyc, d);
          sent++;
        end
      end
    end
    S_VALID = 1'b0;
    START   = 1'b0;
  endtask

  task automatic abort_seq();
    int          sent;
    logic [31:0] d;
    sent = 0;
    @(negedge CLK);
    START    = 1'b1;
    TILE_LEN = 16'd5;
    S_VALID  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      START = 1'b0;
      chk("abort_s_ready", int'(S_READY), 1);
      if (sent == 2) begin
        ABORT   = 1'b1;
        S_VALID = 1'b0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
          if (exp_q[i].due > cyc) exp_q.delete(i);
        end
        break;
      end
      d       = $urandom;
      S_DATA  = d;
      S_VALID = 1'b1;
      push_beat(cyc, d);
      sent++;
    end
    @(negedge CLK);
    ABORT = 1'b0;
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_ready", int'(S_READY), 0);
    chk("abort_en_top", int'(EN_TOP), 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      chk("abort_no_done", int'(DONE), 0);
      chk("abort_idle", int'(BUSY), 0);
    end
  endtask

  task automatic reset_seq();
    @(negedge CLK);
    START    = 1'b1;
    TILE_LEN = 16'd4;
    S_VALID  = 1'b0;
    @(negedge CLK);
    START   = 1'b0;
    S_VALID = 1'b1;
    S_DATA  = 32'h11223344;
    push_beat(cyc, 32'h11223344);
    @(negedge CLK);
    S_DATA = 32'h55667788;
    push_beat(cyc, 32'h55667788);
    #2;
    RSTN = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    S_VALID = 1'b0;
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_ready", int'(S_READY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_array_en", int'(ARRAY_EN), 0);
    chk("rst_a_top", int'(A_TOP), 0);
    #2;
    RSTN = 1'b1;
  endtask

  initial begin
    tbl[0] = '{len: 1, gap_after: 0, gap_cycles: 0, done_lat: 11, drain_start: 0, fixed: 1'b1};
    tbl[1] = '{len: 3, gap_after: 1, gap_cycles: 2, done_lat: 15, drain_start: 0, fixed: 1'b0};
    tbl[2] = '{len: 0, gap_after: 0, gap_cycles: 0, done_lat: 9,  drain_start: 0, fixed: 1'b0};
    tbl[3] = '{len: 1, gap_after: 0, gap_cycles: 0, done_lat: 11, drain_start: 5, fixed: 1'b0};
    tbl[4] = '{len: 4, gap_after: 2, gap_cycles: 1, done_lat: 15, drain_start: 0, fixed: 1'b0};
    tbl[5] = '{len: 3, gap_after: 1, gap_cycles: 3, done_lat: 16, drain_start: 0, fixed: 1'b0};

    RSTN     = 1'b0;
    START    = 1'b0;
    ABORT    = 1'b0;
    TILE_LEN = 16'd0;
    S_VALID  = 1'b0;
    S_DATA   = '0;
    repeat (2) begin
      @(negedge CLK);
      chk("reset_busy", int'(BUSY), 0);
      chk("reset_ready", int'(S_READY), 0);
      chk("reset_done", int'(DONE), 0);
      chk("reset_array_en", int'(ARRAY_EN), 0);
`ifdef ACT_SKEW_PERF_EN
      chk("reset_stall_cnt", int'(STALL_CNT), 0);
`endif
    end
    #2;
    RSTN = 1'b1;

    for (int t = 0; t < 5; t++) begin
      run_tile(tbl[t]);
    end
    abort_seq();
    run_tile(tbl[0]);
    reset_seq();
    run_tile(tbl[5]);
    run_tile(tbl[2]);
    repeat (3) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/act_skew_feeder.md
ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

Interface
REQ-001 The block SHALL have parameter COLS, default 4, meaning the number of array columns fed.
REQ-002 The block SHALL have parameter ROWS, default 4, meaning the number of array rows; it sets the drain length.
REQ-003 The block SHALL have parameter DW, default 8, meaning the signed activation width per lane.
REQ-004 The block SHALL have port CLK  input  1  clock; all state on rising edge.
REQ-005 The block SHALL have port RSTN  input  1  reset; asynchronous, active-low.
REQ-006 The block SHALL have port START  input  1  one-cycle tile start request.
REQ-007 The block SHALL have port ABORT  input  1  synchronous tile cancel.
REQ-008 The block SHALL have port TILE_LEN  input  16  number of activation vectors in the tile; sampled on accepted START.
REQ-009 The block SHALL have port S_VALID  input  1  upstream vector valid.
REQ-010 The block SHALL have port S_READY  output  1  block accepts a vector this cycle.
REQ-011 The block SHALL have port S_DATA  input  COLS*DW  activation vector; lane j is S_DATA[j*DW +: DW].
REQ-012 The block SHALL have port A_TOP  output  COLS*DW  skewed activations to the column tops.
REQ-013 The block SHALL have port EN_TOP  output  COLS  per-column valid to the column tops.
REQ-014 The block SHALL have port ARRAY_EN  output  1  global array enable.
REQ-015 The block SHALL have port BUSY  output  1  high in any state except IDLE.
REQ-016 The block SHALL have port DONE  output  1  one-cycle tile-complete pulse.

Function
REQ-017 The FSM SHALL have states IDLE, STREAM, DRAIN and FINISH.
REQ-018 In IDLE, START=1 SHALL latch TILE_LEN, clear the beat counter and move to STREAM; if TILE_LEN=0, it SHALL move to DRAIN instead.
REQ-019 START SHALL be ignored outside IDLE.
REQ-020 S_READY SHALL equal 1 only in STREAM; a beat is accepted when S_VALID and S_READY are both high.
REQ-021 An accepted beat's lane j SHALL appear on A_TOP lane j with EN_TOP[j]=1 exactly j+1 cycles after acceptance; the delay line is registered with depth j+1.
REQ-022 Any STREAM cycle without an accepted beat SHALL inject a bubble: lane data 0 and EN 0, skewed identically to a beat.
REQ-023 The block SHALL move from STREAM to DRAIN in the cycle after the TILE_LEN-th accepted beat.
REQ-024 DRAIN SHALL inject bubbles for exactly COLS+ROWS cycles using a counter, then move to FINISH.
REQ-025 FINISH SHALL last one cycle with DONE=1, then return to IDLE.
REQ-026 ARRAY_EN SHALL equal BUSY registered by one cycle, so it covers every EN_TOP pulse.
REQ-027 ABORT=1 SHALL take effect in any state: the next state is IDLE, all delay-line stages are cleared to 0/EN 0, and DONE is not pulsed. ABORT SHALL take priority over START.
REQ-028 Activation data SHALL pass through unmodified, signed, DW bits; no arithmetic is performed on it.

Reset
REQ-029 While RSTN=0, the FSM SHALL be IDLE and all delay-line data and EN stages SHALL be 0.
REQ-030 While RSTN=0, S_READY, A_TOP, EN_TOP, ARRAY_EN, BUSY and DONE SHALL be 0, and the beat and drain counters SHALL be 0.
REQ-031 Reset asserted mid-tile SHALL discard the tile; after release the block SHALL be idle and accept a new START.

Configuration
REQ-032 With macro ACT_SKEW_PERF_EN defined, the block SHALL add output STALL_CNT (16 bits) counting STREAM cycles where S_VALID=0. The count SHALL clear on an accepted START, saturate at 0xFFFF and reset to 0.
REQ-033 With ACT_SKEW_PERF_EN undefined, the STALL_CNT port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-034 The bench SHALL cover: COLS=4, TILE_LEN=1, S_DATA lanes {4,3,2,1}, S_VALID held high -> lane j value appears with EN_TOP[j]=1 at cycle j+1 after acceptance; DONE occurs 1+8+1 cycles after the beat.
REQ-035 The bench SHALL cover: TILE_LEN=3 with S_VALID low for 2 cycles between beats 1 and 2 -> 2 bubble cycles (EN 0, data 0) appear in every lane, with beat order preserved.
REQ-036 The bench SHALL cover: TILE_LEN=0 -> no S_READY, straight to DRAIN, DONE 9 cycles after START, EN_TOP never high.
REQ-037 The bench SHALL cover: ABORT during STREAM after 2 of 5 beats -> IDLE next cycle, EN_TOP all 0 next cycle, no DONE, and a new START is accepted.
REQ-038 The bench SHALL cover: START asserted during DRAIN -> ignored, only one DONE.
REQ-039 The bench SHALL cover, with ACT_SKEW_PERF_EN defined: 3 STREAM cycles with S_VALID=0 -> STALL_CNT=3 at DONE, and STALL_CNT=0 after the next START.
